// File: rtl/kd_pkg.sv
// Shared types and constants for the PE2 write-back path of the Kyber/Dilithium NTT datapath.
package kd_pkg;

  localparam int unsigned COEF_W_K    = 12;
  localparam int unsigned COEF_W_D    = 24;
  localparam logic [COEF_W_K-1:0] KYBER_Q     = 12'd3329;
  localparam logic [COEF_W_D-1:0] DILITHIUM_Q = 24'd8380417;

  localparam int unsigned WB_ADDR_W = 6;
  localparam int unsigned WB_DATA_W = 24;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr3;
    logic [WB_DATA_W-1:0] data3;
    logic [WB_ADDR_W-1:0] addr4;
    logic [WB_DATA_W-1:0] data4;
  } wb_entry_t;

  // Single conditional subtraction; inputs are known to lie in [0, 2q).
  function automatic logic [COEF_W_D-1:0] final_reduce(input logic [COEF_W_D-1:0] v,
                                                      input logic kd_mode);
    logic [COEF_W_D-1:0] r;
    r = v;
    if (kd_mode) begin
      if (v >= DILITHIUM_Q) r = v - DILITHIUM_Q;
    end else begin
      if (v[23:12] >= KYBER_Q) r[23:12] = v[23:12] - KYBER_Q;
      if (v[11:0] >= KYBER_Q)  r[11:0]  = v[11:0] - KYBER_Q;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO with occupancy count and a registered head word.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [LVL_W-1:0] level_q, after_pop;
  logic [WIDTH-1:0] head_n;
  logic             push_ok, pop_ok;

  assign push_ok = push & (level_q < FULL_LVL);
  assign pop_ok  = pop & (level_q != '0);
  assign level   = level_q;

  // The head register is loaded with whatever will sit at the read pointer after
  // this edge; a push into an (effectively) empty FIFO bypasses the array.
  always_comb begin
    rd_ptr_n  = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
    after_pop = level_q - LVL_W'(pop_ok);
    head_n    = '0;
    if (after_pop == '0) begin
      if (push_ok) head_n = push_data;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      head_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_n;
      level_q   <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      head_data <= head_n;
    end
  end

endmodule

// File: rtl/pe2_writeback_buf.sv
// PE2 result write-back buffer: FIFO toward the coefficient RAM plus per-stage word counter.
// Optional final modular reduction at push when WB_FINAL_REDUCE_EN is defined.
module pe2_writeback_buf
  import kd_pkg::*;
#(
  parameter int unsigned DATA_W          = 24,
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned WORDS_PER_STAGE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kd_mode,
  input  logic                   stage_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data3,
  input  logic [DATA_W-1:0]      in_data4,
  input  logic [ADDR_W-1:0]      in_addr3,
  input  logic [ADDR_W-1:0]      in_addr4,
  output logic                   wr_en,
  input  logic                   wr_ready,
  output logic [ADDR_W-1:0]      wr_addr3,
  output logic [DATA_W-1:0]      wr_data3,
  output logic [ADDR_W-1:0]      wr_addr4,
  output logic [DATA_W-1:0]      wr_data4,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   stage_done
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(WORDS_PER_STAGE) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_STAGE - 1);

  wb_entry_t        in_entry, head;
  logic             run_q, push, pop;
  logic [CNT_W-1:0] cnt_q, cnt_base;

  // run_q keeps in_ready low until the first edge after reset release.
  assign in_ready = run_q & (fifo_level < FULL_LVL);
  assign wr_en    = (fifo_level != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wr_en & wr_ready;

`ifdef WB_FINAL_REDUCE_EN
  always_comb begin
    in_entry       = '0;
    in_entry.addr3 = in_addr3;
    in_entry.data3 = final_reduce(in_data3, kd_mode);
    in_entry.addr4 = in_addr4;
    in_entry.data4 = final_reduce(in_data4, kd_mode);
  end
`else
  logic unused_kd_mode;
  assign unused_kd_mode = kd_mode;

  always_comb begin
    in_entry       = '0;
    in_entry.addr3 = in_addr3;
    in_entry.data3 = in_data3;
    in_entry.addr4 = in_addr4;
    in_entry.data4 = in_data4;
  end
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head_data (head),
    .level     (fifo_level)
  );

  assign wr_addr3 = head.addr3;
  assign wr_data3 = head.data3;
  assign wr_addr4 = head.addr4;
  assign wr_data4 = head.data4;

  assign cnt_base = stage_start ? '0 : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      stage_done <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      stage_done <= 1'b0;
      if (pop) begin
        if (cnt_base == LAST_CNT) begin
          cnt_q      <= '0;
          stage_done <= 1'b1;
        end else begin
          cnt_q <= cnt_base + CNT_W'(1);
        end
      end else begin
        cnt_q <= cnt_base;
      end
    end
  end

endmodule

// File: tb/tb_pe2_writeback_buf.sv
// Scoreboard bench for pe2_writeback_buf: driver queues expected writes, negedge monitor checks them.
module tb_pe2_writeback_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kd_mode = 1'b1;
  logic        stage_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data3 = '0, in_data4 = '0;
  logic [5:0]  in_addr3 = '0, in_addr4 = '0;
  logic        wr_en;
  logic        wr_ready = 1'b0;
  logic [5:0]  wr_addr3, wr_addr4;
  logic [23:0] wr_data3, wr_data4;
  logic [2:0]  fifo_level;
  logic        stage_done;

  pe2_writeback_buf #(
    .DATA_W          (24),
    .ADDR_W          (6),
    .DEPTH           (4),
    .WORDS_PER_STAGE (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kd_mode     (kd_mode),
    .stage_start (stage_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data3    (in_data3),
    .in_data4    (in_data4),
    .in_addr3    (in_addr3),
    .in_addr4    (in_addr4),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .wr_addr3    (wr_addr3),
    .wr_data3    (wr_data3),
    .wr_addr4    (wr_addr4),
    .wr_data4    (wr_data4),
    .fifo_level  (fifo_level),
    .stage_done  (stage_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  a3;
    logic [23:0] d3;
    logic [5:0]  a4;
    logic [23:0] d4;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0, fails = 0;
  int   wr_count = 0, done_seen = 0, mcnt = 0, base = 0;
  logic exp_done = 1'b0;
  logic mpop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every RAM write against the scoreboard and models the stage counter.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      mcnt     = 0;
      exp_done = 1'b0;
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_wr_data3", 64'(wr_data3), 64'd0);
    end else begin
      check("stage_done", 64'(stage_done), 64'(exp_done));
      if (stage_done) done_seen++;
      mpop = wr_en && wr_ready;
      if (mpop) begin
        wr_count++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr3=%0h data3=%0h, expected no write", wr_addr3, wr_data3);
        end else begin
          e = sb.pop_front();
          check("wr_addr3", 64'(wr_addr3), 64'(e.a3));
          check("wr_data3", 64'(wr_data3), 64'(e.d3));
          check("wr_addr4", 64'(wr_addr4), 64'(e.a4));
          check("wr_data4", 64'(wr_data4), 64'(e.d4));
        end
      end
      base = stage_start ? 0 : mcnt;
      exp_done = 1'b0;
      if (mpop) begin
        if (base + 1 == 64) begin
          mcnt = 0;
          exp_done = 1'b1;
        end else begin
          mcnt = base + 1;
        end
      end else begin
        mcnt = base;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push_pair(input logic [5:0] a3, input logic [23:0] d3,
                           input logic [5:0] a4, input logic [23:0] d4,
                           input logic [23:0] x3, input logic [23:0] x4);
    exp_t x;
    x = '{a3: a3, d3: x3, a4: a4, d4: x4};
    in_valid = 1'b1;
    in_addr3 = a3;
    in_data3 = d3;
    in_addr4 = a4;
    in_data4 = d4;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL push_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  int w0, d0;

  initial begin
    tick(2);
    rst = 1'b1;
    tick(1);

    // 1: reset with three entries queued and the RAM stalled
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_pair(6'(10 + i), 24'h00F000 + 24'(i), 6'(20 + i), 24'h00E000 + 24'(i),
                24'h00F000 + 24'(i), 24'h00E000 + 24'(i));
    check("t1_level_before", 64'(fifo_level), 64'd3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("t1_level", 64'(fifo_level), 64'd0);
    check("t1_wr_en", 64'(wr_en), 64'd0);
    tick(1);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    w0 = wr_count;
    wr_ready = 1'b1;
    tick(3);
    check("t1_no_stale", 64'(wr_count - w0), 64'd0);

    // 2: single push, one-cycle latency
    kd_mode = 1'b1;
    push_pair(6'd5, 24'h000123, 6'd37, 24'h0ABCDE, 24'h000123, 24'h0ABCDE);
    check("t2_wr_en", 64'(wr_en), 64'd1);
    tick(1);
    check("t2_level", 64'(fifo_level), 64'd0);

    // 3: backpressure, fifth pair held until space frees
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_pair(6'(i), 24'h100000 + 24'(i), 6'(32 + i), 24'h200000 + 24'(i),
                24'h100000 + 24'(i), 24'h200000 + 24'(i));
    in_valid = 1'b1;
    @(negedge clk);
    check("t3_in_ready_full", 64'(in_ready), 64'd0);
    check("t3_level_full", 64'(fifo_level), 64'd4);
    tick(1);
    wr_ready = 1'b1;
    w0 = wr_count;
    push_pair(6'd4, 24'h100004, 6'd36, 24'h200004, 24'h100004, 24'h200004);
    tick(3);
    check("t3_level_drained", 64'(fifo_level), 64'd0);
    check("t3_writes", 64'(wr_count - w0), 64'd5);

    // 4: stage counter, 64 pops then one more
    stage_start = 1'b1;
    tick(1);
    stage_start = 1'b0;
    d0 = done_seen;
    for (int i = 0; i < 65; i++)
      push_pair(6'(i), 24'(i * 3), 6'(63 - i), 24'(i * 5), 24'(i * 3), 24'(i * 5));
    tick(4);
    check("t4_done_pulses", 64'(done_seen - d0), 64'd1);

    // 5: final reduction values
    kd_mode = 1'b0;
`ifdef WB_FINAL_REDUCE_EN
    push_pair(6'd1, {12'd3330, 12'd5}, 6'd2, 24'h00A00B, {12'd1, 12'd5}, 24'h00A00B);
`else
    push_pair(6'd1, {12'd3330, 12'd5}, 6'd2, 24'h00A00B, {12'd3330, 12'd5}, 24'h00A00B);
`endif
    kd_mode = 1'b1;
`ifdef WB_FINAL_REDUCE_EN
    push_pair(6'd3, 24'd7, 6'd4, 24'd8380418, 24'd7, 24'd1);
`else
    push_pair(6'd3, 24'd7, 6'd4, 24'd8380418, 24'd7, 24'd8380418);
`endif
    tick(3);

    // 6: simultaneous push and pop at level 2
    wr_ready = 1'b0;
    push_pair(6'd50, 24'h0A0000, 6'd51, 24'h0B0000, 24'h0A0000, 24'h0B0000);
    push_pair(6'd52, 24'h0A0001, 6'd53, 24'h0B0001, 24'h0A0001, 24'h0B0001);
    check("t6_level_start", 64'(fifo_level), 64'd2);
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_pair(6'(i), 24'h0C0000 + 24'(i), 6'(i + 16), 24'h0D0000 + 24'(i),
                24'h0C0000 + 24'(i), 24'h0D0000 + 24'(i));
      check("t6_level_steady", 64'(fifo_level), 64'd2);
    end
    tick(4);
    check("t6_level_end", 64'(fifo_level), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
